// File: rtl/encode_opnds_pkg.sv
// Shared encodings for the IA-32 instruction encoder: operand forms, FSM states,
// prefix bytes and operand-form classification helpers.
package encode_opnds_pkg;

  localparam int MAX_LEN = 13;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  localparam logic [7:0] PFX_OPSIZE   = 8'h66;
  localparam logic [7:0] PFX_ADDRSIZE = 8'h67;

  localparam logic [3:0] OPND_ENC_NONE                = 4'd0;
  localparam logic [3:0] OPND_ENC_REG                 = 4'd1;
  localparam logic [3:0] OPND_ENC_IMM                 = 4'd2;
  localparam logic [3:0] OPND_ENC_REG_IMM             = 4'd3;
  localparam logic [3:0] OPND_ENC_EAX_IMM             = 4'd4;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM         = 4'd5;
  localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM     = 4'd6;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG     = 4'd7;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM_IMM     = 4'd8;
  localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM_IMM = 4'd9;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_IMM = 4'd10;

  // State order is also emission order; the skip logic relies on it.
  typedef enum logic [2:0] {
    ENC_ST_IDLE  = 3'd0,
    ENC_ST_PFX66 = 3'd1,
    ENC_ST_PFX67 = 3'd2,
    ENC_ST_OPC   = 3'd3,
    ENC_ST_MODRM = 3'd4,
    ENC_ST_SIB   = 3'd5,
    ENC_ST_DISP  = 3'd6,
    ENC_ST_IMM   = 3'd7
  } enc_state_t;

  function automatic logic form_has_modrm(input logic [3:0] form);
    return (form >= OPND_ENC_MODREGRM_RM) && (form <= OPND_ENC_MODREGRM_RM_REG_IMM);
  endfunction

  function automatic logic form_has_imm(input logic [3:0] form);
    return (form == OPND_ENC_IMM) || (form == OPND_ENC_REG_IMM) ||
           (form == OPND_ENC_EAX_IMM) || (form == OPND_ENC_MODREGRM_RM_IMM) ||
           (form == OPND_ENC_MODREGRM_REG_RM_IMM) || (form == OPND_ENC_MODREGRM_RM_REG_IMM);
  endfunction

endpackage

// File: rtl/encode_opnds_field_lens.sv
// Combinational field-presence and length calculation for one instruction description.
module encode_field_lens
  import encode_opnds_pkg::*;
(
  input  logic [3:0]       opnd_form,
  input  logic [7:0]       modrm,
  input  logic [7:0]       sib,
  input  logic             operand16,
  input  logic             addr16,
  input  logic             imm_1byte,
  output logic             has_modrm,
  output logic             has_sib,
  output logic             has_imm,
  output logic [2:0]       disp_len,
  output logic [2:0]       imm_len,
  output logic [LEN_W-1:0] total_len
);

  logic [1:0] mod_f;
  logic [2:0] rm_f;

  assign mod_f = modrm[7:6];
  assign rm_f  = modrm[2:0];

  always_comb begin
    has_modrm = form_has_modrm(opnd_form);
    has_imm   = form_has_imm(opnd_form);
    has_sib   = has_modrm & ~addr16 & (mod_f != 2'b11) & (rm_f == 3'b100);
    disp_len  = 3'd0;
    if (has_modrm) begin
      if (addr16) begin
        case (mod_f)
          2'b01:   disp_len = 3'd1;
          2'b10:   disp_len = 3'd2;
          2'b00:   disp_len = (rm_f == 3'b110) ? 3'd2 : 3'd0;
          default: disp_len = 3'd0;
        endcase
      end else begin
        case (mod_f)
          2'b01:   disp_len = 3'd1;
          2'b10:   disp_len = 3'd4;
          // mod 00 with rm 101, or with a SIB whose base is 101, means disp32 without base
          2'b00:   disp_len = ((rm_f == 3'b101) || (has_sib && (sib[2:0] == 3'b101))) ? 3'd4 : 3'd0;
          default: disp_len = 3'd0;
        endcase
      end
    end
    if (!has_imm)       imm_len = 3'd0;
    else if (imm_1byte) imm_len = 3'd1;
    else if (operand16) imm_len = 3'd2;
    else                imm_len = 3'd4;
    total_len = LEN_W'(operand16) + LEN_W'(addr16) + LEN_W'(1) + LEN_W'(has_modrm) +
                LEN_W'(has_sib) + LEN_W'(disp_len) + LEN_W'(imm_len);
  end

endmodule

// File: rtl/encode_opnds.sv
// IA-32 instruction encoder: latches one instruction description and streams its
// bytes (prefixes, opcode, ModR/M, SIB, disp, imm) with valid/ready handshaking.
module encode_opnds
  import encode_opnds_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       opc,
  input  logic [3:0]       opnd_form,
  input  logic             prefix_operand_16bit,
  input  logic             prefix_address_16bit,
  input  logic             imm_1byte,
  input  logic [7:0]       modrm,
  input  logic [7:0]       sib,
  input  logic [31:0]      disp,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [LEN_W-1:0] out_len
);

  enc_state_t       state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             has_modrm_c, has_sib_c, has_imm_c;
  logic [2:0]       disp_len_c, imm_len_c;
  logic [LEN_W-1:0] total_len_c;

  logic [7:0]       opc_p0, modrm_p0, sib_p0;
  logic [31:0]      disp_p0, imm_p0;
  logic             op16_p0, a16_p0, has_modrm_p0, has_sib_p0;
  logic [2:0]       disp_len_p0, imm_len_p0;
  logic [LEN_W-1:0] len_p0;
  logic [7:1]       pres_in, pres_p0;
  logic             field_more;

  encode_field_lens u_lens (
    .opnd_form (opnd_form),
    .modrm     (modrm),
    .sib       (sib),
    .operand16 (prefix_operand_16bit),
    .addr16    (prefix_address_16bit),
    .imm_1byte (imm_1byte),
    .has_modrm (has_modrm_c),
    .has_sib   (has_sib_c),
    .has_imm   (has_imm_c),
    .disp_len  (disp_len_c),
    .imm_len   (imm_len_c),
    .total_len (total_len_c)
  );

  // Lowest-numbered present state after cur; IDLE when nothing is left to emit.
  function automatic enc_state_t next_field(input enc_state_t cur, input logic [7:1] pres);
    enc_state_t nxt;
    nxt = ENC_ST_IDLE;
    for (int i = 7; i >= 1; i--) begin
      if ((3'(i) > cur) && pres[i]) nxt = enc_state_t'(3'(i));
    end
    return nxt;
  endfunction

  assign pres_in = {(imm_len_c != 3'd0), (disp_len_c != 3'd0), has_sib_c, has_modrm_c,
                    1'b1, prefix_address_16bit, prefix_operand_16bit};
  assign pres_p0 = {(imm_len_p0 != 3'd0), (disp_len_p0 != 3'd0), has_sib_p0, has_modrm_p0,
                    1'b1, a16_p0, op16_p0};

  always_comb begin
    field_more = 1'b0;
    if (state == ENC_ST_DISP) field_more = (idx != (disp_len_p0[1:0] - 2'd1));
    if (state == ENC_ST_IMM)  field_more = (idx != (imm_len_p0[1:0] - 2'd1));
  end

  // Stage p0: request capture on accept
  always_ff @(posedge clk) begin
    if ((state == ENC_ST_IDLE) && req_valid) begin
      opc_p0       <= opc;
      modrm_p0     <= modrm;
      sib_p0       <= sib;
      disp_p0      <= disp;
      imm_p0       <= imm;
      op16_p0      <= prefix_operand_16bit;
      a16_p0       <= prefix_address_16bit;
      has_modrm_p0 <= has_modrm_c;
      has_sib_p0   <= has_sib_c;
      disp_len_p0  <= disp_len_c;
      imm_len_p0   <= imm_len_c;
      len_p0       <= total_len_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ENC_ST_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (state == ENC_ST_IDLE) begin
      idx_nxt = 2'd0;
      if (req_valid) state_nxt = next_field(ENC_ST_IDLE, pres_in);
    end else if (out_ready) begin
      if (field_more) begin
        idx_nxt = idx + 2'd1;
      end else begin
        state_nxt = next_field(state, pres_p0);
        idx_nxt   = 2'd0;
      end
    end
  end

  always_comb begin
    req_ready = (state == ENC_ST_IDLE);
    out_valid = (state != ENC_ST_IDLE);
    out_len   = (state == ENC_ST_IDLE) ? '0 : len_p0;
    out_last  = (state != ENC_ST_IDLE) && !field_more && (next_field(state, pres_p0) == ENC_ST_IDLE);
    case (state)
      ENC_ST_PFX66: out_byte = PFX_OPSIZE;
      ENC_ST_PFX67: out_byte = PFX_ADDRSIZE;
      ENC_ST_OPC:   out_byte = opc_p0;
      ENC_ST_MODRM: out_byte = modrm_p0;
      ENC_ST_SIB:   out_byte = sib_p0;
      ENC_ST_DISP:  out_byte = disp_p0[{idx, 3'b000} +: 8];
      ENC_ST_IMM:   out_byte = imm_p0[{idx, 3'b000} +: 8];
      default:      out_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_encode_opnds.sv
// Scoreboard bench for encode_opnds: expected byte streams are queued at request time
// and compared as the encoder hands bytes over, with optional random backpressure.
module tb_encode_opnds;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  opc, modrm, sib;
  logic [3:0]  opnd_form;
  logic        p66, p67, imm_1byte;
  logic [31:0] disp, imm;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic [3:0]  out_len;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [3:0] len;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  bit   bp_en    = 1'b0;
  bit   stall_prev = 1'b0;
  bit   last_prev  = 1'b0;
  logic [7:0] st_byte;
  logic       st_last;
  logic [3:0] st_len;

  always #5 clk = ~clk;

  encode_opnds dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .opc                  (opc),
    .opnd_form            (opnd_form),
    .prefix_operand_16bit (p66),
    .prefix_address_16bit (p67),
    .imm_1byte            (imm_1byte),
    .modrm                (modrm),
    .sib                  (sib),
    .disp                 (disp),
    .imm                  (imm),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_byte             (out_byte),
    .out_last             (out_last),
    .out_len              (out_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bytes are listed first-emitted in the most significant position of seq.
  task automatic push_seq(input logic [103:0] seq, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b    = seq[8*(n-1-i) +: 8];
      e.last = (i == n - 1);
      e.len  = 4'(n);
      sbq.push_back(e);
    end
  endtask

  // Handshake happens at the posedge following this sample, with this out_ready.
  always @(negedge clk) begin
    exp_t e;
    out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (rst) begin
      stall_prev = 1'b0;
      last_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_byte", out_byte, st_byte);
        chk("stall_last", out_last, st_last);
        chk("stall_len",  out_len,  st_len);
        chk("stall_valid", out_valid, 1);
      end
      if (last_prev) begin
        chk("post_last_ready", req_ready, 1);
        chk("post_last_valid", out_valid, 0);
      end
      stall_prev = 1'b0;
      last_prev  = 1'b0;
      if (out_valid) begin
        chk("busy_req_ready", req_ready, 0);
        if (out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_byte", out_valid, 0);
          end else begin
            e = sbq.pop_front();
            chk("byte", out_byte, e.b);
            chk("last", out_last, e.last);
            chk("len",  out_len,  e.len);
            n_popped++;
            last_prev = out_last;
          end
        end else begin
          stall_prev = 1'b1;
          st_byte = out_byte;
          st_last = out_last;
          st_len  = out_len;
        end
      end
    end
  end

  task automatic send(input logic [3:0] f, input logic [7:0] o, input logic a, input logic b,
                      input logic i1, input logic [7:0] m, input logic [7:0] s,
                      input logic [31:0] d, input logic [31:0] iv);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", req_ready, 1);
    opnd_form = f; opc = o; p66 = a; p67 = b; imm_1byte = i1;
    modrm = m; sib = s; disp = d; imm = iv;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("accept_ready_low", req_ready, 0);
    chk("accept_valid", out_valid, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sbq.size() != 0 || !req_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", 32'(sbq.size()), 0);
    chk("drain_idle", req_ready, 1);
  endtask

  initial begin
    int t;
    int base;
    rst = 1'b1; req_valid = 1'b0; opnd_form = 4'd0; opc = 8'h00; p66 = 1'b0; p67 = 1'b0;
    imm_1byte = 1'b0; modrm = 8'h00; sib = 8'h00; disp = 32'h0; imm = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_byte",  out_byte,  0);
    chk("rst_out_len",   out_len,   0);
    rst = 1'b0;

    // reg,r/m with register operand
    push_seq(104'h8BC1, 2);
    send(4'd6, 8'h8B, 0, 0, 0, 8'hC1, 8'h00, 32'h0, 32'h0);
    wait_done();

    // disp32-only addressing plus imm32
    push_seq(104'h81_05_44332211_DDCCBBAA, 10);
    send(4'd8, 8'h81, 0, 0, 0, 8'h05, 8'h00, 32'h11223344, 32'hAABBCCDD);
    wait_done();

    // 16-bit immediate, then 1-byte immediate
    push_seq(104'h66B83412, 4);
    send(4'd3, 8'hB8, 1, 0, 0, 8'h00, 8'h00, 32'h0, 32'h00001234);
    wait_done();
    push_seq(104'h66B834, 3);
    send(4'd3, 8'hB8, 1, 0, 1, 8'h00, 8'h00, 32'h0, 32'h00001234);
    wait_done();

    // SIB with disp8, then 16-bit addressing where the same ModR/M has no SIB
    push_seq(104'h8B44247F, 4);
    send(4'd6, 8'h8B, 0, 0, 0, 8'h44, 8'h24, 32'h0000007F, 32'h0);
    wait_done();
    push_seq(104'h678B447F, 4);
    send(4'd6, 8'h8B, 0, 1, 0, 8'h44, 8'h24, 32'h0000007F, 32'h0);
    wait_done();

    // mod 00 with SIB base 101 takes disp32
    push_seq(104'hFF0425EFBEADDE, 7);
    send(4'd5, 8'hFF, 0, 0, 0, 8'h04, 8'h25, 32'hDEADBEEF, 32'h0);
    wait_done();

    // both prefixes, 16-bit disp16 via mod 10, imm16
    push_seq(104'h6667C786EFBE7856, 8);
    send(4'd8, 8'hC7, 1, 1, 0, 8'h86, 8'h00, 32'h0000BEEF, 32'h00005678);
    wait_done();

    // one-byte instruction
    push_seq(104'h90, 1);
    send(4'd0, 8'h90, 0, 0, 0, 8'h00, 8'h00, 32'h0, 32'h0);
    wait_done();

    // backpressure on the long form
    bp_en = 1'b1;
    push_seq(104'h81_05_44332211_DDCCBBAA, 10);
    send(4'd8, 8'h81, 0, 0, 0, 8'h05, 8'h00, 32'h11223344, 32'hAABBCCDD);
    wait_done();
    bp_en = 1'b0;
    @(negedge clk);

    // reset while the third byte is on the bus
    base = n_popped;
    push_seq(104'h8105, 2);
    sbq[sbq.size()-1].last = 1'b0;
    sbq[sbq.size()-2].len  = 4'd10;
    sbq[sbq.size()-1].len  = 4'd10;
    send(4'd8, 8'h81, 0, 0, 0, 8'h05, 8'h00, 32'h11223344, 32'hAABBCCDD);
    t = 0;
    while (n_popped < base + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("abort_reached_byte3", 32'(n_popped - base), 2);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_last",  out_last,  0);
    chk("abort_ready", req_ready, 1);
    chk("abort_queue", 32'(sbq.size()), 0);

    push_seq(104'h66B83412, 4);
    send(4'd3, 8'hB8, 1, 0, 0, 8'h00, 8'h00, 32'h0, 32'h00001234);
    wait_done();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
